// File: rtl/la_pkg.sv
// Shared types and defaults for the logic-analyser capture path.
package la_pkg;
    localparam int LA_N         = 16;
    localparam int LA_AW        = 10;
    localparam int PRIME_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;
endpackage

// File: rtl/capture_addr_ctr.sv
// Wrapping sample-RAM write address counter; clear has priority over increment.
module capture_addr_ctr
    import la_pkg::*;
#(
    parameter int AW = LA_AW
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW-1:0] o_addr
);

    logic [AW-1:0] r_addr;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_addr <= '0;
        end else if (i_clr) begin
            r_addr <= '0;
        end else if (i_inc) begin
            r_addr <= r_addr + AW'(1);
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/capture_sequencer.sv
// Run-control FSM for one acquisition: prime the edge coder, fill pre-trigger history, trigger, post-fill.
// Optional trigger timeout is built when TRIG_TIMEOUT_EN is defined.
module capture_sequencer
    import la_pkg::*;
#(
    parameter int N  = LA_N,
    parameter int AW = LA_AW,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          arm,
    input  logic          abort,
    input  logic [N-1:0]  edge_in,
    input  logic [N-1:0]  trig_mask,
    input  logic [AW-1:0] pre_cnt,
    input  logic [AW-1:0] post_cnt,
    output logic          coder_en,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          triggered,
    output logic [AW-1:0] trig_addr,
    output logic          done
`ifdef TRIG_TIMEOUT_EN
    ,
    input  logic [TW-1:0] timeout_lim,
    output logic          timed_out
`endif
);

    localparam logic [AW:0]   DEPTH      = (AW+1)'(1) << AW;
    localparam logic [AW-1:0] PRIME_LAST = AW'(PRIME_CYCLES - 1);

    state_t        r_state, w_next;
    logic [AW-1:0] r_pre, r_post, r_cnt;
    logic          r_triggered;
    logic [AW-1:0] r_trig_addr;
    logic          w_arm_ok, w_edge_hit, w_force, w_trig;
    logic          w_run, w_wr, w_done, w_cnt_run;
    logic [AW:0]   w_sum;
    logic [AW-1:0] w_pre_eff;

    if (TW < 1) begin : g_bad_tw
        $error("TW must be at least 1");
    end

    assign w_arm_ok   = arm & ~abort & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_edge_hit = |(edge_in & trig_mask);
    assign w_trig     = (r_state == S_WAIT) & (w_edge_hit | w_force);

    // Clamp so the trigger sample survives the circular overwrite; ~post == 2**AW-1-post.
    assign w_sum     = {1'b0, pre_cnt} + {1'b0, post_cnt} + (AW+1)'(1);
    assign w_pre_eff = (w_sum > DEPTH) ? ~post_cnt : pre_cnt;

`ifdef TRIG_TIMEOUT_EN
    logic [TW-1:0] r_to_cnt;
    logic          r_timed_out;

    assign w_force = (timeout_lim != '0) && (r_to_cnt == timeout_lim);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_to_cnt    <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_WAIT) ? r_to_cnt + TW'(1) : '0;
            if (abort || w_arm_ok) begin
                r_timed_out <= 1'b0;
            end else if (w_trig && w_force && !w_edge_hit) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign timed_out = r_timed_out;
`else
    assign w_force = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_run     = 1'b0;
        w_wr      = 1'b0;
        w_done    = 1'b0;
        w_cnt_run = 1'b0;
        case (r_state)
            S_IDLE: if (arm) w_next = S_PRIME;
            S_PRIME: begin
                w_run     = 1'b1;
                w_cnt_run = 1'b1;
                if (r_cnt == PRIME_LAST) w_next = (r_pre == '0) ? S_WAIT : S_PRE;
            end
            S_PRE: begin
                w_run     = 1'b1;
                w_wr      = 1'b1;
                w_cnt_run = 1'b1;
                if (r_cnt == r_pre - AW'(1)) w_next = S_WAIT;
            end
            S_WAIT: begin
                w_run = 1'b1;
                w_wr  = 1'b1;
                if (w_trig) w_next = (r_post == '0) ? S_DONE : S_POST;
            end
            S_POST: begin
                w_run     = 1'b1;
                w_wr      = 1'b1;
                w_cnt_run = 1'b1;
                if (r_cnt == r_post - AW'(1)) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (arm) w_next = S_PRIME;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pre       <= '0;
            r_post      <= '0;
            r_triggered <= 1'b0;
            r_trig_addr <= '0;
        end else begin
            r_state <= w_next;
            // One counter serves the prime, pre and post phases; it restarts on every state change.
            r_cnt   <= (w_cnt_run && (w_next == r_state)) ? r_cnt + AW'(1) : '0;
            if (w_arm_ok) begin
                r_pre  <= w_pre_eff;
                r_post <= post_cnt;
            end
            if (abort || w_arm_ok) begin
                r_triggered <= 1'b0;
            end else if (w_trig) begin
                r_triggered <= 1'b1;
                r_trig_addr <= wr_addr;
            end
        end
    end

    capture_addr_ctr #(.AW(AW)) u_addr (
        .clk    (clk),
        .nreset (nreset),
        .i_clr  (w_arm_ok),
        .i_inc  (w_wr),
        .o_addr (wr_addr)
    );

    assign coder_en  = w_run;
    assign busy      = w_run;
    assign wr_en     = w_wr;
    assign done      = w_done;
    assign triggered = r_triggered;
    assign trig_addr = r_trig_addr;

endmodule
